unit_control: RTL and testbench

Main decoder of the hybrid ARM/MIPS datapath: turns the 10-bit instruction header into every datapath control strobe for the next pipeline stage. It sits between the fetch/instruction register and the register file, ALU, PAU, data memory, pixel memory and IO port. All outputs are registered so they align with the decode/execute pipeline boundary.

---
 rtl/unit_control_pkg.sv | 49 ++++
 rtl/unit_control_decode.sv | 90 +++++++++
 rtl/unit_control.sv | 60 ++++++
 tb/tb_unit_control.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/unit_control_pkg.sv
// Shared types and encodings for the ARM/MIPS main decoder.
// The PAU decode is enabled by defining UNIT_CONTROL_PAU_EN.
package unit_control_pkg;

   typedef enum logic [1:0] {
      OpDp  = 2'b00,
      OpRsv = 2'b01,
      OpMem = 2'b10,
      OpExt = 2'b11
   } op_class_e;

   // Op 11 sub-opcodes, header bits [4:2]
   localparam logic [2:0] SubBranch = 3'b000;
   localparam logic [2:0] SubIoOut  = 3'b001;
   localparam logic [2:0] SubIoIn   = 3'b010;
   localparam logic [2:0] SubPauReg = 3'b100;
   localparam logic [2:0] SubPauImm = 3'b101;

   localparam logic [3:0] AluAdd = 4'b0100;
   localparam logic [3:0] AluSub = 4'b0010;
   localparam logic [3:0] AluCmp = 4'b1010;

   localparam logic [1:0] WbResult = 2'b00;
   localparam logic [1:0] WbData   = 2'b01;
   localparam logic [1:0] WbPixel  = 2'b10;
   localparam logic [1:0] WbIo     = 2'b11;

   typedef struct packed {
      logic       rn_src;
      logic       imm_src;
      logic       rs_src;
      logic       result_src;
      logic       io_flag;
      logic       pau_op;
      logic       imm_ext;
      logic       flag_write;
      logic       alu_src;
      logic       branch_inst;
      logic       mem_write;
      logic       reg_write;
      logic       mem_p_write;
      logic [3:0] alu_control;
      logic [2:0] cond_flag;
      logic [1:0] mem_to_reg;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/unit_control_decode.sv
// Combinational instruction-header to control-word decode.
// Op 11 PAU sub-opcodes decode only when UNIT_CONTROL_PAU_EN is defined.
module unit_control_decode
   import unit_control_pkg::*;
(
   input  logic [9:0] inst_header,
   output ctrl_t      ctrl
);

   logic [2:0] cond;
   logic [4:0] funct;
   op_class_e  op;
   logic       legal;
   ctrl_t      c;

   assign cond  = inst_header[9:7];
   assign funct = inst_header[6:2];
   assign op    = op_class_e'(inst_header[1:0]);

   always_comb begin
      c     = CTRL_NOP;
      legal = 1'b1;
      unique case (op)
         OpDp: begin
            c.alu_control = funct[3:0];
            c.alu_src     = funct[4];
            if (funct[3:0] == AluCmp) begin
               c.reg_write  = 1'b0;
               c.flag_write = 1'b1;
            end else begin
               c.reg_write  = 1'b1;
               c.flag_write = funct[3];
            end
            c.mem_to_reg = WbResult;
         end
         OpRsv: legal = 1'b0;
         OpMem: begin
            // funct[0] = load, funct[1] = pixel memory, funct[2] = add offset
            c.alu_src     = 1'b1;
            c.alu_control = funct[2] ? AluAdd : AluSub;
            if (funct[0]) begin
               c.reg_write  = 1'b1;
               c.mem_to_reg = funct[1] ? WbPixel : WbData;
            end else begin
               c.rs_src      = 1'b1;
               c.mem_p_write = funct[1];
               c.mem_write   = ~funct[1];
            end
         end
         OpExt: begin
            case (funct[2:0])
               SubBranch: begin
                  c.branch_inst = 1'b1;
                  c.rn_src      = 1'b1;
                  c.imm_src     = 1'b1;
                  c.imm_ext     = 1'b1;
                  c.alu_src     = 1'b1;
                  c.alu_control = AluAdd;
               end
               SubIoOut: begin
                  c.io_flag = 1'b1;
                  c.rs_src  = 1'b1;
               end
               SubIoIn: begin
                  c.io_flag    = 1'b1;
                  c.reg_write  = 1'b1;
                  c.mem_to_reg = WbIo;
               end
`ifdef UNIT_CONTROL_PAU_EN
               SubPauReg, SubPauImm: begin
                  c.result_src = 1'b1;
                  c.reg_write  = 1'b1;
                  c.pau_op     = funct[4];
                  c.alu_src    = (funct[2:0] == SubPauImm);
               end
`endif
               default: legal = 1'b0;
            endcase
         end
         default: legal = 1'b0;
      endcase
      c.cond_flag = cond;
      if (!legal) begin
         c = CTRL_NOP;
      end
   end

   assign ctrl = c;

endmodule

// File: rtl/unit_control.sv
// Main decoder top: registers the decoded control word at the decode/execute boundary.
// Define UNIT_CONTROL_PAU_EN to enable the PAU instruction decode.
module unit_control
   import unit_control_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] InstHeader,
   output logic       RnSrc,
   output logic       ImmSrc,
   output logic       RsSrc,
   output logic       ResultSrc,
   output logic       IOFlag,
   output logic       PAUOp,
   output logic       ImmExt,
   output logic       FlagWrite,
   output logic       ALUSrc,
   output logic       BranchInst,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       MemPWrite,
   output logic [3:0] ALUControl,
   output logic [2:0] CondFlag,
   output logic [1:0] MemToReg
);

   ctrl_t ctrl_d;
   ctrl_t ctrl_q;

   unit_control_decode u_decode (
      .inst_header (InstHeader),
      .ctrl        (ctrl_d)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q <= CTRL_NOP;
      end else begin
         ctrl_q <= ctrl_d;
      end
   end

   assign RnSrc      = ctrl_q.rn_src;
   assign ImmSrc     = ctrl_q.imm_src;
   assign RsSrc      = ctrl_q.rs_src;
   assign ResultSrc  = ctrl_q.result_src;
   assign IOFlag     = ctrl_q.io_flag;
   assign PAUOp      = ctrl_q.pau_op;
   assign ImmExt     = ctrl_q.imm_ext;
   assign FlagWrite  = ctrl_q.flag_write;
   assign ALUSrc     = ctrl_q.alu_src;
   assign BranchInst = ctrl_q.branch_inst;
   assign MemWrite   = ctrl_q.mem_write;
   assign RegWrite   = ctrl_q.reg_write;
   assign MemPWrite  = ctrl_q.mem_p_write;
   assign ALUControl = ctrl_q.alu_control;
   assign CondFlag   = ctrl_q.cond_flag;
   assign MemToReg   = ctrl_q.mem_to_reg;

endmodule

// File: tb/tb_unit_control.sv
// Scoreboard bench for unit_control: directed and random headers against a behavioural model.
// Model follows UNIT_CONTROL_PAU_EN the same way the design does.
module tb_unit_control;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] hdr = '0;
   logic       RnSrc, ImmSrc, RsSrc, ResultSrc, IOFlag, PAUOp, ImmExt, FlagWrite;
   logic       ALUSrc, BranchInst, MemWrite, RegWrite, MemPWrite;
   logic [3:0] ALUControl;
   logic [2:0] CondFlag;
   logic [1:0] MemToReg;

   int n_checks = 0;
   int n_pass   = 0;

   logic [21:0] exp_q[$];
   logic [9:0]  hdr_q[$];

   unit_control dut (
      .clk        (clk),
      .rst        (rst),
      .InstHeader (hdr),
      .RnSrc      (RnSrc),
      .ImmSrc     (ImmSrc),
      .RsSrc      (RsSrc),
      .ResultSrc  (ResultSrc),
      .IOFlag     (IOFlag),
      .PAUOp      (PAUOp),
      .ImmExt     (ImmExt),
      .FlagWrite  (FlagWrite),
      .ALUSrc     (ALUSrc),
      .BranchInst (BranchInst),
      .MemWrite   (MemWrite),
      .RegWrite   (RegWrite),
      .MemPWrite  (MemPWrite),
      .ALUControl (ALUControl),
      .CondFlag   (CondFlag),
      .MemToReg   (MemToReg)
   );

   always #5 clk = ~clk;

   // Bit order: RnSrc ImmSrc RsSrc ResultSrc IOFlag PAUOp ImmExt FlagWrite ALUSrc
   //            BranchInst MemWrite RegWrite MemPWrite ALUControl[4] CondFlag[3] MemToReg[2]
   function automatic logic [21:0] observed();
      return {RnSrc, ImmSrc, RsSrc, ResultSrc, IOFlag, PAUOp, ImmExt, FlagWrite, ALUSrc,
              BranchInst, MemWrite, RegWrite, MemPWrite, ALUControl, CondFlag, MemToReg};
   endfunction

   function automatic logic [21:0] model(input logic [9:0] h);
      logic rn = 0, imms = 0, rs = 0, res = 0, io = 0, pau = 0, ext = 0, fw = 0;
      logic asrc = 0, br = 0, mw = 0, rw = 0, mpw = 0, ok = 1;
      logic [3:0] alu = 0;
      logic [1:0] wb = 0;
      int sub = int'(h[4:2]);
      if (h[1:0] == 2'd0) begin
         alu  = h[5:2];
         asrc = h[6];
         rw   = (alu != 4'd10);
         fw   = (alu == 4'd10) ? 1'b1 : h[5];
      end else if (h[1:0] == 2'd1) begin
         ok = 0;
      end else if (h[1:0] == 2'd2) begin
         asrc = 1;
         alu  = h[4] ? 4'd4 : 4'd2;
         if (h[2]) begin
            rw = 1;
            wb = h[3] ? 2'd2 : 2'd1;
         end else begin
            rs  = 1;
            mpw = h[3];
            mw  = !h[3];
         end
      end else if (sub == 0) begin
         br = 1; rn = 1; imms = 1; ext = 1; asrc = 1; alu = 4'd4;
      end else if (sub == 1) begin
         io = 1; rs = 1;
      end else if (sub == 2) begin
         io = 1; rw = 1; wb = 2'd3;
      end else if (sub == 4 || sub == 5) begin
`ifdef UNIT_CONTROL_PAU_EN
         res = 1; rw = 1; pau = h[6]; asrc = (sub == 5);
`else
         ok = 0;
`endif
      end else begin
         ok = 0;
      end
      if (!ok) return '0;
      return {rn, imms, rs, res, io, pau, ext, fw, asrc, br, mw, rw, mpw, alu, h[9:7], wb};
   endfunction

   task automatic check(input string name, input logic [21:0] got, input logic [21:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s got=%b exp=%b", name, got, want);
   endtask

   task automatic issue(input logic [9:0] h);
      @(negedge clk);
      hdr = h;
      exp_q.push_back(model(h));
      hdr_q.push_back(h);
   endtask

   // Monitor: output register loads every edge, so one expectation retires per edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!rst && exp_q.size() > 0) begin
            logic [21:0] e;
            logic [9:0]  h;
            e = exp_q.pop_front();
            h = hdr_q.pop_front();
            check($sformatf("hdr_%b", h), observed(), e);
         end
      end
   end

   logic [9:0] directed[16] = '{
      10'b0000000010, 10'b0000001010, 10'b0000010010, 10'b0000100000,
      10'b0000101000, 10'b0000111000, 10'b0001000000, 10'b0000000011,
      10'b0000000111, 10'b0000001011, 10'b0000010011, 10'b0000010111,
      10'b0000011011, 10'b0000000001, 10'b1010100000, 10'b1101010111
   };

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", observed(), '0);
      @(negedge clk);
      rst = 1'b0;

      foreach (directed[i]) issue(directed[i]);
      // Leave a non-NOP word registered so the asynchronous clear is visible
      issue(10'b1110000011);

      @(negedge clk);
      #1;
      check("pre_reset_nonzero", {21'd0, observed() != '0}, 22'd1);
      rst = 1'b1;
      hdr = 10'b0000000010;
      #1;
      check("reset_async", observed(), '0);
      @(posedge clk);
      #1;
      check("reset_hold", observed(), '0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_release", observed(), '0);
      exp_q.push_back(model(hdr));
      hdr_q.push_back(hdr);

      for (int i = 0; i < 300; i++) issue(10'($urandom_range(0, 1023)));

      repeat (3) @(posedge clk);
      #2;
      check("queue_drained", {exp_q.size() != 0, 21'd0}, '0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
